// File: rtl/cnt_timer_sched.sv
// Round-robin scheduler that time-shares one cnt divider/counter between N_REQ requesters.
// Each grant programs cnt, waits for cnt_q, then returns a done pulse and the captured count.

`ifndef CTRL_RESET_AND_SIGNAL_IF_EQUAL
`define CTRL_RESET_AND_SIGNAL_IF_EQUAL 3'b001
`endif
`ifndef CTRL_COUNTDOWN_AND_SIGNAL_IF_EQUAL
`define CTRL_COUNTDOWN_AND_SIGNAL_IF_EQUAL 3'b010
`endif

module cnt_timer_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 32,
  localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_div,
  input  logic [N_REQ-1:0]    req_mode,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic [DW-1:0]       done_count,
  output logic                busy,
  output logic [IW-1:0]       cur_id,
  output logic [DW-1:0]       cnt_div,
  output logic [2:0]          cnt_control,
  input  logic                cnt_q,
  input  logic [DW-1:0]       cnt_dout
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      id_q, id_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               mode_q, mode_d;
  logic [DW-1:0]      cnt_div_q, cnt_div_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic [DW-1:0]      count_q, count_d;

  logic [DW-1:0]      div_arr [N_REQ];
  logic               grant_valid;
  logic [IW-1:0]      grant_id;
  logic [IW-1:0]      cand;

  for (genvar g = 0; g < N_REQ; g++) begin : g_div
    assign div_arr[g] = req_div[g*DW +: DW];
  end

  // Scan starts just after the last serviced id, so it has lowest priority.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IW'((32'(rr_ptr_q) + off) % N_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    rr_ptr_d  = rr_ptr_q;
    mode_d    = mode_q;
    cnt_div_d = cnt_div_q;
    ctrl_d    = ctrl_q;
    done_d    = '0;
    err_d     = 1'b0;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        ctrl_d = 3'b000;
        if (grant_valid) begin
          id_d      = grant_id;
          mode_d    = req_mode[grant_id];
          cnt_div_d = div_arr[grant_id];
          if (div_arr[grant_id] == '0) begin
            state_d          = StDone;
            done_d[grant_id] = 1'b1;
            err_d            = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (!req[id_q]) begin
          state_d = StIdle;
        end else begin
          state_d = StRun;
          ctrl_d  = mode_q ? `CTRL_COUNTDOWN_AND_SIGNAL_IF_EQUAL
                           : `CTRL_RESET_AND_SIGNAL_IF_EQUAL;
        end
      end
      StRun: begin
        // Completion takes priority over a simultaneous cancel.
        if (cnt_q) begin
          count_d      = cnt_dout;
          state_d      = StDone;
          ctrl_d       = 3'b000;
          done_d[id_q] = 1'b1;
        end else if (!req[id_q]) begin
          state_d = StIdle;
          ctrl_d  = 3'b000;
        end
      end
      StDone: begin
        rr_ptr_d = id_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      id_q      <= '0;
      rr_ptr_q  <= IW'(N_REQ - 1);
      mode_q    <= 1'b0;
      cnt_div_q <= '0;
      ctrl_q    <= 3'b000;
      done_q    <= '0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
      mode_q    <= mode_d;
      cnt_div_q <= cnt_div_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign done        = done_q;
  assign err         = err_q;
  assign done_count  = count_q;
  assign busy        = (state_q != StIdle);
  assign cur_id      = id_q;
  assign cnt_div     = cnt_div_q;
  assign cnt_control = ctrl_q;

endmodule
